// File: rtl/screen_painter.sv
// screen_painter: full-screen raster painter for the opening/win/loss screens.
// Sweeps the WIDTH x HEIGHT frame in raster order, reads each pixel's colour
// from an external synchronous picture ROM and emits one plot per clock.
// Optional feature macro: SCREEN_BORDER_EN (forces a white one-pixel frame border).
module screen_painter #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [1:0]  screen_select,
    output logic [16:0] rom_address,
    input  logic [2:0]  rom_data,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn,
    output logic        done
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q;
    logic          arm_q;
    logic          flush_q;
    logic [1:0]    sel_q;
    logic [CW-1:0] cx_q;
    logic [CW-1:0] cy_q;

    // Stage 1: coordinates travelling alongside the ROM read
    logic [CW-1:0] cx1_q;
    logic [CW-1:0] cy1_q;
    logic          valid1_q;

    // Stage 2: plot outputs
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic [2:0]    colour_q;
    logic          we_q;
    logic          done_q;

    logic [2:0]    pix_colour;

    // ROM address is a pure concatenation of registered sweep state
    assign rom_address = {sel_q, cy_q[6:0], cx_q[7:0]};

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = we_q;
    assign done    = done_q;

`ifdef SCREEN_BORDER_EN
    // Border pixels are painted white regardless of the picture contents
    assign pix_colour = (cx1_q == '0 || cx1_q == X_LAST || cy1_q == '0 || cy1_q == Y_LAST)
                        ? 3'b111 : rom_data;
`else
    assign pix_colour = rom_data;
`endif

    // Control FSM, sweep counters and stage-1 pipeline register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            arm_q    <= 1'b1;
            flush_q  <= 1'b0;
            sel_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            cx1_q    <= '0;
            cy1_q    <= '0;
            valid1_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Stage 1 captures the address presented this cycle; valid only while sweeping
            cx1_q    <= cx_q;
            cy1_q    <= cy_q;
            valid1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && arm_q) begin
                        state_q <= S_SWEEP;
                        sel_q   <= screen_select;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end else if (!enable) begin
                        arm_q <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else begin
                        valid1_q <= 1'b1;
                        if (cx_q == X_LAST) begin
                            cx_q <= '0;
                            if (cy_q == Y_LAST) begin
                                cy_q    <= '0;
                                flush_q <= 1'b0;
                                state_q <= S_FLUSH;
                            end else begin
                                cy_q <= cy_q + CW'(1);
                            end
                        end else begin
                            cx_q <= cx_q + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Two cycles let the last pixel leave stage 2 before done rises
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (flush_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        arm_q   <= 1'b0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Low enable observed here also re-arms, so a one-cycle low restarts
                    if (!enable) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        arm_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 2: register the plot coordinates, strobe and ROM colour
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            x_q      <= cx1_q;
            y_q      <= cy1_q;
            colour_q <= pix_colour;
            we_q     <= valid1_q;
        end
    end

endmodule

// File: tb/tb_screen_painter.sv
// Self-checking bench for screen_painter: randomized screens, ROM contents,
// abort points and reset timing against a raster-order reference model.
module tb_screen_painter;

    localparam int W = 160;
    localparam int H = 120;
    localparam int NPIX = W * H;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [1:0]  screen_select;
    logic [16:0] rom_address;
    logic [2:0]  rom_data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        done;

    logic        rom_mix;
    int          n_cmp;
    int          n_err;

    screen_painter #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .screen_select (screen_select),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .writeEn       (writeEn),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous picture ROM model
    always @(posedge clk) begin
        if (rom_mix)
            rom_data <= rom_address[2:0] ^ rom_address[10:8] ^ {1'b0, rom_address[16:15]};
        else
            rom_data <= rom_address[2:0];
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected colour of pixel (px,py) of screen s, from the picture contents
    function automatic logic [2:0] exp_col(input logic [1:0] s, input int px, input int py);
        logic [2:0] c;
        c = rom_mix ? (3'(px) ^ 3'(py) ^ {1'b0, s}) : 3'(px);
`ifdef SCREEN_BORDER_EN
        if (px == 0 || px == W - 1 || py == 0 || py == H - 1) c = 3'b111;
`endif
        return c;
    endfunction

    // Request a paint of screen sel; optionally change screen_select at cycle
    // toggle_at, or drop enable after abort_at plots (0 = run the full frame).
    task automatic sweep(input logic [1:0] sel, input logic [1:0] sel2,
                         input int toggle_at, input int abort_at);
        int c, nplot, first_we, last_we, done_c, bad_pix, bad_sel, extra, dn, px, py;
        int last_xy;
        @(negedge clk);
        enable = 1'b1;
        screen_select = sel;
        c = 0; nplot = 0; first_we = -1; last_we = -1; done_c = -1;
        bad_pix = 0; bad_sel = 0; last_xy = -1;
        while (c < NPIX + 200 && done_c < 0 && !(abort_at > 0 && nplot >= abort_at)) begin
            @(negedge clk);
            c++;
            if (c == toggle_at) screen_select = sel2;
            if (c <= NPIX && rom_address[16:15] != sel) bad_sel++;
            if (writeEn) begin
                if (first_we < 0) first_we = c;
                last_we = c;
                px = nplot % W;
                py = nplot / W;
                if (int'(x) != px || int'(y) != py || colour != exp_col(sel, px, py)) bad_pix++;
                last_xy = {x, y};
                nplot++;
            end
            if (done) done_c = c;
        end
        check("first_plot_cycle", first_we, 3);
        check("rom_select_latched", bad_sel, 0);
        if (abort_at > 0) begin
            enable = 1'b0;
            @(negedge clk);
            if (writeEn) begin
                px = nplot % W;
                py = nplot / W;
                if (int'(x) != px || int'(y) != py || colour != exp_col(sel, px, py)) bad_pix++;
                nplot++;
            end
            @(negedge clk);
            check("abort_we_low", int'(writeEn), 0);
            extra = 0; dn = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (writeEn) extra++;
                if (done) dn++;
            end
            check("abort_no_plots", extra, 0);
            check("abort_no_done", dn, 0);
            check("abort_pixels", bad_pix, 0);
        end else begin
            check("plot_count", nplot, NPIX);
            check("last_plot_cycle", last_we, NPIX + 2);
            check("done_cycle", done_c, NPIX + 3);
            check("pixel_stream", bad_pix, 0);
            check("last_plot_xy", last_xy, {10'(W - 1), 10'(H - 1)});
        end
    endtask

    // With enable still high after completion, done holds and no new sweep starts
    task automatic hold_done(input int n);
        int we_cnt, nd_cnt;
        we_cnt = 0; nd_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (writeEn) we_cnt++;
            if (!done) nd_cnt++;
        end
        check("held_no_resweep", we_cnt, 0);
        check("held_done_level", nd_cnt, 0);
    endtask

    initial begin
        logic [1:0] s;
        int wait_n;
        n_cmp = 0; n_err = 0;
        resetn = 1'b0; enable = 1'b0; screen_select = 2'd0; rom_mix = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({x, y, colour, writeEn, done, rom_address}), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Plain address-pattern ROM, screen 1
        sweep(2'd1, 2'd1, 0, 0);
        hold_done(50);

        // Enable low for exactly one cycle, then repaint a random screen with mixed ROM
        @(negedge clk);
        enable = 1'b0;
        rom_mix = 1'b1;
        s = 2'($urandom_range(0, 2));
        sweep(s, s, 0, 0);
        hold_done(20);
        @(negedge clk);
        enable = 1'b0;
        check("done_falls", int'(done), 1);
        @(negedge clk);
        check("done_cleared", int'(done), 0);

        // Abort at plot 5000, then restart with select changing mid-sweep
        sweep(2'd0, 2'd0, 0, 5000);
        sweep(2'd2, 2'd0, $urandom_range(100, NPIX - 100), 0);

        // Asynchronous reset mid-sweep
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        screen_select = 2'($urandom_range(0, 2));
        wait_n = $urandom_range(200, 600);
        repeat (wait_n) @(negedge clk);
        check("mid_sweep_active", int'(writeEn), 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({x, y, colour, writeEn, done, rom_address}), 0);
        enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", int'({writeEn, done}), 0);
        sweep(2'd1, 2'd1, 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
